// File: rtl/waveform_buffer_pkg.sv
// Display geometry shared by the waveform buffer and the waveform renderer.
// Changing the trace length or sample format here keeps both blocks consistent.
package waveform_buffer_pkg;
   localparam int DISP_DEPTH = 1024;
   localparam int SAMPLE_W   = 9;
   localparam int COL_W      = 11;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic [COL_W-1:0]           col_t;
endpackage

// File: rtl/waveform_buffer_sample_ram.sv
// Simple dual-port sample store: one write port and one registered read port.
// A read and a write to the same address in one cycle return the old word.
module sample_ram
   import waveform_buffer_pkg::*;
#(
   parameter int DEPTH = DISP_DEPTH
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  sample_t                    wr_data,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr,
   output sample_t                    rd_data
);

   sample_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/waveform_buffer.sv
// Decimating circular trace buffer; each frame latches a snapshot of the write
// pointer and fill so a whole frame is drawn from one consistent window.
module waveform_buffer
   import waveform_buffer_pkg::*;
#(
   parameter int DEPTH    = DISP_DEPTH,
   parameter int DECIMATE = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       sample_valid,
   input  logic signed [SAMPLE_W-1:0] sample_in,
   input  logic                       freeze,
   input  logic                       frame_start,
   input  logic [COL_W-1:0]           hcount,
   output logic signed [SAMPLE_W-1:0] signal_out,
   output logic                       out_valid,
   output logic [$clog2(DEPTH):0]     fill
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;
   localparam int CW = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
   localparam logic [CW-1:0] DEC_LAST = CW'(DECIMATE - 1);
   localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

   logic [CW-1:0] dec_cnt;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] base_ptr;
   logic [FW-1:0] fill_lat;
   logic          accept;
   logic          wr_en;

   logic [AW-1:0] rd_addr_p0;
   logic          col_ok_p0;
   sample_t       rd_data_p1;
   logic          vld_p1;

   assign accept = sample_valid & ~freeze;
   assign wr_en  = accept & (dec_cnt == '0);

   // Stage 0: column address relative to the frame snapshot; fill gating
   // hides columns older than what has been written since reset.
   assign rd_addr_p0 = base_ptr + AW'(hcount);
   assign col_ok_p0  = (int'(hcount) < DEPTH) &&
                       ((int'(hcount) + int'(fill_lat)) >= DEPTH);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dec_cnt  <= '0;
         wr_ptr   <= '0;
         base_ptr <= '0;
         fill     <= '0;
         fill_lat <= '0;
         vld_p1   <= 1'b0;
      end else begin
         if (accept) dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 1'b1;
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (fill != FILL_MAX) fill <= fill + 1'b1;
         end
         // Non-blocking update gives the pre-write pointer on a coincident write.
         if (frame_start) begin
            base_ptr <= wr_ptr;
            fill_lat <= fill;
         end
         vld_p1 <= col_ok_p0;
      end
   end

   sample_ram #(.DEPTH(DEPTH)) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (sample_in),
      .rd_addr (rd_addr_p0),
      .rd_data (rd_data_p1)
   );

   // Stage 1: registered RAM word, forced to zero where no real sample exists.
   assign signal_out = vld_p1 ? rd_data_p1 : '0;
   assign out_valid  = vld_p1;

endmodule

// File: tb/tb_waveform_buffer.sv
// Bench for waveform_buffer: two instances (DECIMATE=1 and 4) share stimulus,
// each checked per column against a sample-history scoreboard plus spot checks.
module tb_waveform_buffer;
   localparam int DEPTH = 1024;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              sample_valid;
   logic signed [8:0] sample_in;
   logic              freeze;
   logic              frame_start;
   logic [10:0]       hcount;

   logic signed [8:0] sig1, sig4;
   logic              vld1, vld4;
   logic [10:0]       fill1, fill4;

   int n_tests = 0;
   int n_fail  = 0;

   int          s1[$];
   int          s4[$];
   int          nf_m[2];
   int          acc_m[2];
   logic [9:0]  sb1[$];
   logic [9:0]  sb4[$];
   int          last_hc;

   always #5 clk = ~clk;

   waveform_buffer #(.DEPTH(DEPTH), .DECIMATE(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_in(sample_in),
      .freeze(freeze), .frame_start(frame_start), .hcount(hcount),
      .signal_out(sig1), .out_valid(vld1), .fill(fill1)
   );

   waveform_buffer #(.DEPTH(DEPTH), .DECIMATE(4)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_in(sample_in),
      .freeze(freeze), .frame_start(frame_start), .hcount(hcount),
      .signal_out(sig4), .out_valid(vld4), .fill(fill4)
   );

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30) $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Expected {valid, sample} for column c: the window is the DEPTH most recent
   // samples at the frame snapshot; a RAM slot holds the latest write to it.
   function automatic logic [9:0] exp_col(input int d, input int c);
      int nf, n, fl, idx0, i, v;
      nf = nf_m[d];
      n  = (d == 0) ? s1.size() : s4.size();
      fl = (nf < DEPTH) ? nf : DEPTH;
      if (c >= DEPTH || c < DEPTH - fl) return 10'd0;
      idx0 = nf - DEPTH + c;
      i = idx0 + DEPTH * ((n - 1 - idx0) / DEPTH);
      v = (d == 0) ? s1[i] : s4[i];
      return {1'b1, v[8:0]};
   endfunction

   task automatic model_edge();
      last_hc = int'(hcount);
      if (!reset_n) begin
         sb1.push_back(10'd0);
         sb4.push_back(10'd0);
         s1.delete();
         s4.delete();
         nf_m  = '{0, 0};
         acc_m = '{0, 0};
      end else begin
         sb1.push_back(exp_col(0, last_hc));
         sb4.push_back(exp_col(1, last_hc));
         if (frame_start) begin
            nf_m[0] = s1.size();
            nf_m[1] = s4.size();
         end
         if (sample_valid && !freeze) begin
            s1.push_back(int'(sample_in));
            if (acc_m[1] % 4 == 0) s4.push_back(int'(sample_in));
            acc_m[0]++;
            acc_m[1]++;
         end
      end
   endtask

   task automatic step();
      logic [9:0] e;
      @(posedge clk);
      model_edge();
      #1;
      while (sb1.size() > 0) begin
         e = sb1.pop_front();
         chk_eq($sformatf("d1_col%0d", last_hc), {22'd0, vld1, sig1}, {22'd0, e});
      end
      while (sb4.size() > 0) begin
         e = sb4.pop_front();
         chk_eq($sformatf("d4_col%0d", last_hc), {22'd0, vld4, sig4}, {22'd0, e});
      end
   endtask

   task automatic put_sample(input int v);
      sample_valid = 1'b1;
      sample_in    = 9'(v);
      step();
      sample_valid = 1'b0;
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
   endtask

   task automatic sweep(input int lo, input int hi);
      for (int c = lo; c <= hi; c++) begin
         hcount = 11'(c);
         step();
      end
      hcount = 11'd2047;
   endtask

   task automatic peek(input int c);
      hcount = 11'(c);
      step();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0; sample_valid = 1'b0; sample_in = '0;
      freeze = 1'b0; frame_start = 1'b0; hcount = 11'd2047;
      nf_m = '{0, 0}; acc_m = '{0, 0};
      repeat (3) step();
      reset_n = 1'b1;
      step();
      chk_eq("rst_fill1", {21'd0, fill1}, 0);
      chk_eq("rst_fill4", {21'd0, fill4}, 0);
      chk_eq("rst_vld1", {31'd0, vld1}, 0);

      // Ten samples, undecimated view in columns 1014..1023
      for (int v = 1; v <= 10; v++) put_sample(v);
      chk_eq("a_fill1", {21'd0, fill1}, 10);
      chk_eq("a_fill4", {21'd0, fill4}, 3);
      pulse_frame();
      sweep(0, 1023);
      peek(1014); chk_eq("a_c1014", {23'd0, sig1}, 1);  chk_eq("a_v1014", {31'd0, vld1}, 1);
      peek(1023); chk_eq("a_c1023", {23'd0, sig1}, 10); chk_eq("a4_c1023", {23'd0, sig4}, 9);
      peek(1013); chk_eq("a_v1013", {31'd0, vld1}, 0);  chk_eq("a_c1013", {23'd0, sig1}, 0);

      // Decimate by 4: values 0..15 keep 0,4,8,12
      do_reset();
      for (int v = 0; v < 16; v++) put_sample(v);
      chk_eq("b_fill4", {21'd0, fill4}, 4);
      chk_eq("b_fill1", {21'd0, fill1}, 16);
      pulse_frame();
      for (int k = 0; k < 4; k++) begin
         peek(1020 + k);
         chk_eq($sformatf("b_dec%0d", k), {23'd0, sig4}, 32'(4 * k));
         chk_eq($sformatf("b_vld%0d", k), {31'd0, vld4}, 1);
      end
      peek(1019); chk_eq("b_v1019", {31'd0, vld4}, 0);
      sweep(0, 1023);

      // Wrap-around: 1030 samples
      do_reset();
      for (int n = 0; n < 1030; n++) put_sample(n % 512);
      chk_eq("c_fill1", {21'd0, fill1}, 1024);
      chk_eq("c_fill4", {21'd0, fill4}, 258);
      pulse_frame();
      peek(0);    chk_eq("c_col0", {23'd0, sig1}, 6);
      peek(1023); chk_eq("c_col1023", {23'd0, sig1}, 1029 % 512);
      sweep(0, 1023);

      // Freeze: samples ignored, frame repeats, decimation phase kept
      freeze = 1'b1;
      for (int k = 0; k < 50; k++) put_sample(100 + k);
      pulse_frame();
      chk_eq("d_fill1", {21'd0, fill1}, 1024);
      chk_eq("d_fill4", {21'd0, fill4}, 258);
      sweep(0, 1023);
      peek(0); chk_eq("d_col0", {23'd0, sig1}, 6);
      freeze = 1'b0;
      put_sample(40); put_sample(41); put_sample(42);
      chk_eq("d_fill4_resume", {21'd0, fill4}, 259);
      pulse_frame();
      peek(1023); chk_eq("d4_phase", {23'd0, sig4}, 42);
      sweep(0, 1023);

      // Frame start coincident with a write
      do_reset();
      for (int v = 1; v <= 5; v++) put_sample(v);
      sample_valid = 1'b1; sample_in = 9'd77; frame_start = 1'b1;
      step();
      sample_valid = 1'b0; frame_start = 1'b0;
      peek(1023); chk_eq("e_c1023", {23'd0, sig1}, 5);
      peek(1018); chk_eq("e_v1018", {31'd0, vld1}, 0);
      sweep(0, 1023);
      pulse_frame();
      peek(1023); chk_eq("e_next", {23'd0, sig1}, 77);
      chk_eq("e_fill1", {21'd0, fill1}, 6);

      // Reset mid-frame with a full buffer
      do_reset();
      for (int n = 0; n < 1024; n++) put_sample(n % 256);
      pulse_frame();
      sweep(0, 500);
      hcount = 11'd501;
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      chk_eq("f_vld", {31'd0, vld1}, 0);
      chk_eq("f_fill1", {21'd0, fill1}, 0);
      chk_eq("f_fill4", {21'd0, fill4}, 0);
      sweep(502, 1023);
      peek(1023); chk_eq("f_v1023", {31'd0, vld1}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
